dmem_bridge: RTL and testbench

- Sits directly downstream of the datapath MEM stage, between its memory port (mem_ren/mem_wen/mem_addr/mem_dout/mem_din) and a variable-latency external data bus with a req/ack handshake.
- Converts each MEM-stage access into one bus transaction and asserts a stall to the pipeline controller until the transaction completes.
- Presents read data to the datapath for exactly the cycle the pipeline advances.
- Detects misaligned accesses and bus timeouts.

---
 rtl/dmem_bridge_pkg.sv | 17 +
 rtl/dmem_bridge_if.sv | 33 +++
 rtl/dmem_bridge_wait_timer.sv | 36 +++
 rtl/dmem_bridge.sv | 100 ++++++++++
 tb/tb_dmem_bridge.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the MEM-stage data bridge: FSM state encodings,
// the read data returned on an aborted access, and the bus address helper.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// MEM-stage port plus external req/ack data bus; master is the bridge,
// slave is the pipeline/memory side.
interface dmem_bridge_if;

    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        mem_misalign;
    logic        mem_timeout;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        input  mem_ren, mem_wen, mem_addr, mem_dout, bus_ack, bus_rdata,
        output mem_din, mem_stall, mem_misalign, mem_timeout,
        output bus_req, bus_we, bus_addr, bus_wdata
    );

    modport slave (
        output mem_ren, mem_wen, mem_addr, mem_dout, bus_ack, bus_rdata,
        input  mem_din, mem_stall, mem_misalign, mem_timeout,
        input  bus_req, bus_we, bus_addr, bus_wdata
    );

endinterface

// File: rtl/dmem_bridge_wait_timer.sv
// Wait-cycle counter: synchronous clear, count enable, terminal count at
// TIMEOUT-1. Saturates at terminal count so it can never wrap.
module wait_timer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// Turns each MEM-stage access into one req/ack bus transaction, stalling the
// pipeline until it completes; read data is presented in the DONE cycle.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    dmem_bridge_if.master bif
);

    state_e      state_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [31:0] rdata_q;
    logic        timeout_q;

    logic acc;
    logic aligned;
    logic start;
    logic in_busy;
    logic tmr_tc;

    assign acc     = bif.mem_ren | bif.mem_wen;
    assign aligned = (bif.mem_addr[1:0] == 2'b00);
    assign start   = (state_q == ST_IDLE) && acc && aligned;
    assign in_busy = (state_q == ST_BUSY);

    // Gated by rst so an access held at the inputs cannot stall the pipe during reset.
    assign bif.mem_stall    = !rst && (start || in_busy);
    assign bif.mem_misalign = !rst && (state_q == ST_IDLE) && acc && !aligned;
    assign bif.mem_timeout  = timeout_q;
    assign bif.mem_din      = rdata_q;
    assign bif.bus_req      = bus_req_q;
    assign bif.bus_we       = bus_we_q;
    assign bif.bus_addr     = bus_addr_q;
    assign bif.bus_wdata    = bus_wdata_q;

    wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (!in_busy),
        .en_i  (in_busy && !bif.bus_ack),
        .tc_o  (tmr_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= bif.mem_wen;
                        bus_addr_q  <= word_align(bif.mem_addr);
                        bus_wdata_q <= bif.mem_dout;
                        state_q     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // An ack in the terminal-count cycle still completes normally.
                    if (bif.bus_ack) begin
                        bus_req_q <= 1'b0;
                        if (!bus_we_q) begin
                            rdata_q <= bif.bus_rdata;
                        end
                        state_q <= ST_DONE;
                    end else if (tmr_tc) begin
                        bus_req_q <= 1'b0;
                        rdata_q   <= TIMEOUT_RDATA;
                        timeout_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    timeout_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: table of single accesses, bus-side scoreboard, and
// hand-written timeout, back-to-back and mid-transaction reset sequences.
module tb_dmem_bridge;

    logic clk;
    logic rst;

    dmem_bridge_if bif();
    dmem_bridge_if bif_to();

    dmem_bridge #(.TIMEOUT(16), .CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bif (bif)
    );

    dmem_bridge #(.TIMEOUT(4), .CNT_W(8)) u_dut_to (
        .clk (clk),
        .rst (rst),
        .bif (bif_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sb_t;

    sb_t sb_q[$];
    sb_t cur;
    bit  in_txn = 1'b0;

    // Bus monitor: pops one expected transaction per bus_req assertion and
    // checks the request fields on every cycle it is held.
    always @(negedge clk) begin
        if (rst) begin
            in_txn = 1'b0;
        end else if (bif.bus_req) begin
            if (!in_txn) begin
                if (sb_q.size() == 0) begin
                    chk1("unexpected_bus_req", bif.bus_req, 1'b0);
                end else begin
                    cur    = sb_q.pop_front();
                    in_txn = 1'b1;
                end
            end
            if (in_txn) begin
                chk1("bus_we", bif.bus_we, cur.we);
                chk("bus_addr", bif.bus_addr, cur.addr);
                chk("bus_wdata", bif.bus_wdata, cur.wdata);
            end
        end else begin
            in_txn = 1'b0;
        end
    end

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        logic        exp_mis;
        int          exp_stall;
        logic        exp_we;
        logic [31:0] exp_baddr;
    } vec_t;

    vec_t        vecs[7];
    logic [31:0] din_model = 32'h0;

    // Entered and left at posedge+1; drives one access to completion.
    task automatic do_access(input vec_t v);
        int stalls;
        int reqs;
        stalls = 0;
        reqs   = 0;
        bif.mem_ren  = v.ren;
        bif.mem_wen  = v.wen;
        bif.mem_addr = v.addr;
        bif.mem_dout = v.wdata;
        bif.bus_ack  = 1'b0;
        if (!v.exp_mis) sb_q.push_back('{we: v.exp_we, addr: v.exp_baddr, wdata: v.wdata});
        @(negedge clk);
        chk1("misalign", bif.mem_misalign, v.exp_mis);
        if (bif.mem_stall) stalls++;
        for (int k = 1; k <= v.delay; k++) begin
            @(posedge clk); #1;
            bif.bus_ack   = (k == v.delay);
            bif.bus_rdata = (k == v.delay) ? v.rdata : 32'hDEAD_BEEF;
            @(negedge clk);
            if (bif.mem_stall) stalls++;
            if (bif.bus_req) reqs++;
        end
        if (!v.exp_mis) begin
            @(posedge clk); #1;
            bif.bus_ack   = 1'b0;
            bif.bus_rdata = 32'hBAD0_BAD0;
            @(negedge clk);
            if (!v.exp_we) din_model = v.rdata;
            chk1("done_stall", bif.mem_stall, 1'b0);
            chk1("done_bus_req", bif.bus_req, 1'b0);
            chk("done_din", bif.mem_din, din_model);
            chk1("done_timeout", bif.mem_timeout, 1'b0);
        end
        @(posedge clk); #1;
        bif.mem_ren = 1'b0;
        bif.mem_wen = 1'b0;
        @(negedge clk);
        chk1("idle_stall", bif.mem_stall, 1'b0);
        chk1("idle_bus_req", bif.bus_req, 1'b0);
        chk("idle_din", bif.mem_din, din_model);
        chk("stall_cycles", 32'(stalls), 32'(v.exp_stall));
        chk("req_cycles", 32'(reqs), v.exp_mis ? 32'd0 : 32'(v.delay));
        @(posedge clk); #1;
    endtask

    initial begin
        int reqs;

        //            ren   wen   addr           wdata          dly rdata          mis  stl we    baddr
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 1, 32'h1234_5678, 1'b0, 2, 1'b0, 32'h0000_0100};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 5, 32'h0BAD_0BAD, 1'b0, 6, 1'b1, 32'h0000_0204};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0102, 32'h0000_0000, 0, 32'h0000_0000, 1'b1, 0, 1'b0, 32'h0000_0000};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_030C, 32'h0000_BEEF, 2, 32'h7777_7777, 1'b0, 3, 1'b1, 32'h0000_030C};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0401, 32'h1111_2222, 0, 32'h0000_0000, 1'b1, 0, 1'b0, 32'h0000_0000};
        vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 3, 32'hA5A5_5A5A, 1'b0, 4, 1'b0, 32'hFFFF_FFFC};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 4, 32'h0000_0001, 1'b0, 5, 1'b0, 32'h0000_0008};

        rst = 1'b1;
        bif.mem_ren = 1'b0;    bif.mem_wen = 1'b0;    bif.mem_addr = '0;    bif.mem_dout = '0;
        bif.bus_ack = 1'b0;    bif.bus_rdata = '0;
        bif_to.mem_ren = 1'b0; bif_to.mem_wen = 1'b0; bif_to.mem_addr = '0; bif_to.mem_dout = '0;
        bif_to.bus_ack = 1'b0; bif_to.bus_rdata = '0;

        // Reset state
        @(negedge clk);
        chk1("rst_bus_req", bif.bus_req, 1'b0);
        chk1("rst_bus_we", bif.bus_we, 1'b0);
        chk("rst_bus_addr", bif.bus_addr, 32'h0);
        chk("rst_bus_wdata", bif.bus_wdata, 32'h0);
        chk("rst_din", bif.mem_din, 32'h0);
        chk1("rst_timeout", bif.mem_timeout, 1'b0);
        chk1("rst_stall", bif.mem_stall, 1'b0);
        chk1("rst_misalign", bif.mem_misalign, 1'b0);
        chk1("rst_to_bus_req", bif_to.bus_req, 1'b0);
        chk("rst_to_din", bif_to.mem_din, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("post_rst_stall", bif.mem_stall, 1'b0);
        chk1("post_rst_bus_req", bif.bus_req, 1'b0);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) do_access(vecs[i]);

        // Back-to-back reads, each acked on the first BUSY cycle
        bif.mem_ren = 1'b1; bif.mem_addr = 32'h10; bif.mem_dout = 32'h0;
        sb_q.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0});
        @(negedge clk); chk1("b2b_a_stall_idle", bif.mem_stall, 1'b1);
        @(posedge clk); #1; bif.bus_ack = 1'b1; bif.bus_rdata = 32'h1111_0010;
        @(negedge clk); chk1("b2b_a_req", bif.bus_req, 1'b1);
        @(posedge clk); #1; bif.bus_ack = 1'b0; bif.bus_rdata = 32'h0;
        @(negedge clk);
        chk("b2b_a_din", bif.mem_din, 32'h1111_0010);
        chk1("b2b_a_done_stall", bif.mem_stall, 1'b0);
        chk1("b2b_a_done_req", bif.bus_req, 1'b0);
        @(posedge clk); #1; bif.mem_addr = 32'h14;
        sb_q.push_back('{we: 1'b0, addr: 32'h14, wdata: 32'h0});
        @(negedge clk); chk1("b2b_b_stall_idle", bif.mem_stall, 1'b1);
        @(posedge clk); #1; bif.bus_ack = 1'b1; bif.bus_rdata = 32'h2222_0014;
        @(negedge clk); chk("b2b_b_addr", bif.bus_addr, 32'h14);
        @(posedge clk); #1; bif.bus_ack = 1'b0;
        @(negedge clk); chk("b2b_b_din", bif.mem_din, 32'h2222_0014);
        din_model = 32'h2222_0014;
        @(posedge clk); #1; bif.mem_ren = 1'b0;
        @(negedge clk); chk1("b2b_idle_stall", bif.mem_stall, 1'b0);
        @(posedge clk); #1;

        // Reset in the second BUSY cycle, late ack, then a normal access
        bif.mem_ren = 1'b1; bif.mem_addr = 32'h80; bif.mem_dout = 32'h0;
        sb_q.push_back('{we: 1'b0, addr: 32'h80, wdata: 32'h0});
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk); chk1("rstmid_busy1_req", bif.bus_req, 1'b1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk1("rstmid_async_req", bif.bus_req, 1'b0);
        chk1("rstmid_async_stall", bif.mem_stall, 1'b0);
        @(negedge clk);
        chk("rstmid_din", bif.mem_din, 32'h0);
        chk("rstmid_bus_addr", bif.bus_addr, 32'h0);
        @(posedge clk); #1;
        bif.mem_ren = 1'b0; bif.bus_ack = 1'b1; bif.bus_rdata = 32'h9999_9999;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("late_ack_req", bif.bus_req, 1'b0);
        chk1("late_ack_stall", bif.mem_stall, 1'b0);
        chk("late_ack_din", bif.mem_din, 32'h0);
        @(posedge clk); #1;
        @(negedge clk); chk("late_ack_din_hold", bif.mem_din, 32'h0);
        @(posedge clk); #1; bif.bus_ack = 1'b0;
        din_model = 32'h0;
        do_access('{1'b1, 1'b0, 32'h84, 32'h0, 2, 32'h8484_8484, 1'b0, 3, 1'b0, 32'h84});

        // TIMEOUT=4 instance: good read, timeout read, ack on the terminal cycle
        bif_to.mem_ren = 1'b1; bif_to.mem_addr = 32'h20;
        @(negedge clk);
        @(posedge clk); #1; bif_to.bus_ack = 1'b1; bif_to.bus_rdata = 32'h5555_AAAA;
        @(posedge clk); #1; bif_to.bus_ack = 1'b0;
        @(negedge clk); chk("to_pre_din", bif_to.mem_din, 32'h5555_AAAA);
        @(posedge clk); #1; bif_to.mem_ren = 1'b0;
        @(posedge clk); #1;

        bif_to.mem_ren = 1'b1; bif_to.mem_addr = 32'h40;
        @(negedge clk); chk1("to_idle_stall", bif_to.mem_stall, 1'b1);
        reqs = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bif_to.bus_req) reqs++;
            chk1("to_busy_stall", bif_to.mem_stall, 1'b1);
            chk1("to_busy_timeout", bif_to.mem_timeout, 1'b0);
        end
        chk("to_req_cycles", 32'(reqs), 32'd4);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("to_done_req", bif_to.bus_req, 1'b0);
        chk1("to_done_timeout", bif_to.mem_timeout, 1'b1);
        chk("to_done_din", bif_to.mem_din, 32'h0);
        chk1("to_done_stall", bif_to.mem_stall, 1'b0);
        @(posedge clk); #1; bif_to.mem_ren = 1'b0;
        @(negedge clk);
        chk1("to_idle_timeout", bif_to.mem_timeout, 1'b0);
        chk1("to_idle_stall2", bif_to.mem_stall, 1'b0);
        @(posedge clk); #1;

        bif_to.mem_ren = 1'b1; bif_to.mem_addr = 32'h44;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            bif_to.bus_ack   = (k == 4);
            bif_to.bus_rdata = 32'h0F0F_F0F0;
        end
        @(negedge clk); chk1("to_edge_req", bif_to.bus_req, 1'b1);
        @(posedge clk); #1; bif_to.bus_ack = 1'b0;
        @(negedge clk);
        chk1("to_edge_timeout", bif_to.mem_timeout, 1'b0);
        chk("to_edge_din", bif_to.mem_din, 32'h0F0F_F0F0);
        @(posedge clk); #1; bif_to.mem_ren = 1'b0;
        @(posedge clk); #1;

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
